// File: rtl/fp16_cmp_arb.sv
// fp16_cmp_arb: round-robin arbiter sharing one combinational fp16 comparator
// among NUM_REQ requesters. The winning requester's compare result is
// registered with its ID in a one-entry output slot (valid/ready). A
// saturating counter tracks how many unordered (NaN) results were accepted.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid[NUM_REQ]    per-requester request valid
//   req_a/req_b           packed operands, requester i at [16*i+15:16*i]
//   req_ready[NUM_REQ]    one-hot grant (transfer = req_valid & req_ready)
//   rsp_valid/rsp_ready   output slot handshake
//   rsp_id                requester that owns the slot result
//   rsp_lt/eq/gt/unord    compare result (exactly one set)
//   unord_cnt             saturating count of accepted unordered results

// Combinational IEEE half-precision compare.
module fp16_cmp (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        lt,
    output logic        eq,
    output logic        gt,
    output logic        unord
);
    logic a_nan, b_nan, both_zero, mag_lt;

    assign a_nan     = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    assign b_nan     = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    assign both_zero = (a[14:0] == 15'd0) && (b[14:0] == 15'd0);
    assign mag_lt    = a[14:0] < b[14:0];

    always_comb begin
        lt    = 1'b0;
        eq    = 1'b0;
        gt    = 1'b0;
        unord = 1'b0;
        if (a_nan || b_nan) begin
            unord = 1'b1;
        end else if (both_zero || (a == b)) begin
            eq = 1'b1;
        end else if (a[15] != b[15]) begin
            // Signs differ and not both zero: the positive one is larger.
            gt = ~a[15];
            lt = a[15];
        end else if (!a[15]) begin
            lt = mag_lt;
            gt = ~mag_lt;
        end else begin
            // Both negative: larger magnitude is the smaller value.
            lt = ~mag_lt;
            gt = mag_lt;
        end
    end
endmodule

module fp16_cmp_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_lt,
    output logic                   rsp_eq,
    output logic                   rsp_gt,
    output logic                   rsp_unord,
    output logic [CNT_W-1:0]       unord_cnt
);
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W:0]      scan;
    logic               found;
    logic               slot_free;
    logic               xfer;
    logic [15:0]        a_sel, b_sel;
    logic               c_lt, c_eq, c_gt, c_unord;

    assign slot_free = !rsp_valid || rsp_ready;

    // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid wins.
    // scan is one bit wider than rr_ptr so the sum cannot overflow.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        scan    = '0;
        if (!rst && slot_free) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
                if (scan >= (ID_W+1)'(NUM_REQ))
                    scan = scan - (ID_W+1)'(NUM_REQ);
                if (!found && req_valid[scan[ID_W-1:0]]) begin
                    found                 = 1'b1;
                    gnt_idx               = scan[ID_W-1:0];
                    grant[scan[ID_W-1:0]] = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = found;

    // One-hot operand mux into the shared comparator.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[16*i +: 16];
                b_sel = req_b[16*i +: 16];
            end
        end
    end

    fp16_cmp u_cmp (
        .a     (a_sel),
        .b     (b_sel),
        .lt    (c_lt),
        .eq    (c_eq),
        .gt    (c_gt),
        .unord (c_unord)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_lt    <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_unord <= 1'b0;
            unord_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                // Covers both an empty slot and drain+load in the same cycle.
                rsp_valid <= 1'b1;
                rsp_id    <= gnt_idx;
                rsp_lt    <= c_lt;
                rsp_eq    <= c_eq;
                rsp_gt    <= c_gt;
                rsp_unord <= c_unord;
                rr_ptr    <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
                if (c_unord && (unord_cnt != {CNT_W{1'b1}}))
                    unord_cnt <= unord_cnt + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp16_cmp_arb.sv
// Self-checking bench for fp16_cmp_arb. A reference model predicts grants
// and compare results; expected responses are queued on each predicted
// transfer and compared against the output slot while it is valid.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_fp16_cmp_arb;
    typedef struct packed {
        logic [1:0] id;
        logic       lt;
        logic       eq;
        logic       gt;
        logic       un;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_ready, req_ready2;
    logic        rsp_valid, rsp_valid2;
    logic        rsp_ready;
    logic [1:0]  rsp_id, rsp_id2;
    logic        rsp_lt, rsp_eq, rsp_gt, rsp_unord;
    logic        rsp_lt2, rsp_eq2, rsp_gt2, rsp_unord2;
    logic [15:0] unord_cnt;
    logic [1:0]  unord_cnt2;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_ptr;
    logic        m_full;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;
    rsp_t        exp_q[$];

    fp16_cmp_arb #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt),
        .rsp_unord(rsp_unord), .unord_cnt(unord_cnt)
    );

    fp16_cmp_arb #(.NUM_REQ(4), .ID_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id2), .rsp_lt(rsp_lt2), .rsp_eq(rsp_eq2), .rsp_gt(rsp_gt2),
        .rsp_unord(rsp_unord2), .unord_cnt(unord_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // Totally ordered integer key: sign-magnitude to two's complement,
    // so +0 and -0 both map to 0 and infinities sit at the extremes.
    function automatic int key(input logic [15:0] x);
        int m;
        m = int'(x[14:0]);
        return x[15] ? -m : m;
    endfunction

    function automatic rsp_t model(input int i);
        logic [15:0] a, b;
        logic [31:0] iv;
        rsp_t r;
        a    = req_a[16*i +: 16];
        b    = req_b[16*i +: 16];
        iv   = i;
        r    = '0;
        r.id = iv[1:0];
        if (is_nan(a) || is_nan(b)) r.un = 1'b1;
        else begin
            r.lt = key(a) <  key(b);
            r.eq = key(a) == key(b);
            r.gt = key(a) >  key(b);
        end
        return r;
    endfunction

    // One clock: check outputs at the falling edge against the model,
    // advance the model, then return 1 time unit after the rising edge.
    task automatic cycle(output int gnt, output rsp_t seen, output logic seen_v);
        logic [3:0] eg;
        logic       sf;
        int         idx;
        rsp_t       e;
        @(negedge clk);
        eg  = '0;
        gnt = -1;
        sf  = !m_full || rsp_ready;
        if (!rst && sf)
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (gnt < 0 && req_valid[idx]) begin
                    gnt     = idx;
                    eg[idx] = 1'b1;
                end
            end
        seen_v = rsp_valid;
        seen   = {rsp_id, rsp_lt, rsp_eq, rsp_gt, rsp_unord};
        chk("req_ready", req_ready, eg);
        chk("req_ready_w2", req_ready2, eg);
        chk("rsp_valid", rsp_valid, m_full);
        if (m_full && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("rsp_fields", seen, e);
        end
        chk("unord_cnt", unord_cnt, m_cnt);
        chk("unord_cnt_w2", unord_cnt2, m_cnt2);
        if (rst) begin
            m_full = 1'b0; m_ptr = 0; m_cnt = '0; m_cnt2 = '0;
            exp_q.delete();
        end else begin
            if (m_full && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (gnt >= 0) begin
                e = model(gnt);
                exp_q.push_back(e);
                if (e.un) begin
                    if (m_cnt  != 16'hFFFF) m_cnt  = m_cnt + 1'b1;
                    if (m_cnt2 != 2'b11)    m_cnt2 = m_cnt2 + 1'b1;
                end
                m_ptr = (gnt + 1) % 4;
            end
            m_full = (m_full && !rsp_ready) || (gnt >= 0);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] sp[8];
        sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h3C00, 16'hBC00, 16'h7C01};
        if ($urandom_range(1, 0) == 1) return sp[$urandom_range(7, 0)];
        return 16'($urandom);
    endfunction

    initial begin
        int   g;
        rsp_t s;
        logic sv;
        int   exp_seq[5];
        int   sat_seq[5];

        exp_seq = '{0, 1, 2, 3, 0};
        sat_seq = '{1, 2, 3, 3, 3};
        m_ptr = 0; m_full = 1'b0; m_cnt = '0; m_cnt2 = '0;

        // lane operands: lt, eq (+0/-0), gt (inf vs max), lt (negatives)
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = {16'hC000, 16'h7C00, 16'h0000, 16'h3C00};
        req_b     = {16'hBC00, 16'h7BFF, 16'h8000, 16'h4000};
        @(posedge clk); #1;

        // 1. reset held two cycles with all valid
        cycle(g, s, sv);
        cycle(g, s, sv);
        chk("rst_ready", req_ready, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cnt", unord_cnt, 16'd0);
        rst = 1'b0;
        cycle(g, s, sv);
        chk("first_grant", g, 0);
        req_valid = 4'h0;
        cycle(g, s, sv);

        // 2. single request on lane 0 (pointer now at 1, wraps to 0)
        req_valid = 4'h1;
        cycle(g, s, sv);
        chk("single_grant", g, 0);
        req_valid = 4'h0;
        cycle(g, s, sv);
        chk("single_valid", sv, 1'b1);
        chk("single_id", s.id, 2'd0);
        chk("single_lt", s.lt, 1'b1);

        // 3. round-robin with all lanes valid, also covers eq/gt/lt specials
        rst = 1'b1;
        cycle(g, s, sv);
        rst = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            cycle(g, s, sv);
            chk("rr_seq", g, exp_seq[k]);
            if (k > 0) chk("rr_no_bubble", sv, 1'b1);
            if (k == 2) chk("zero_eq", s.eq, 1'b1);
            if (k == 3) chk("inf_gt", s.gt, 1'b1);
            if (k == 4) chk("neg_lt", s.lt, 1'b1);
        end

        // 4. backpressure: slot full, three stalled cycles, then drain+grant
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(g, s, sv);
            chk("bp_no_grant", g, -1);
            chk("bp_stable_id", s.id, 2'd0);
        end
        rsp_ready = 1'b1;
        cycle(g, s, sv);
        chk("bp_resume_grant", g, 1);

        // 5. NaN operand counts once
        req_valid = 4'h0;
        cycle(g, s, sv);
        cycle(g, s, sv);
        req_a[15:0] = 16'h7E00;
        req_b[15:0] = 16'h3C00;
        req_valid   = 4'h1;
        cycle(g, s, sv);
        req_valid = 4'h0;
        cycle(g, s, sv);
        chk("nan_unord", s.un, 1'b1);
        chk("nan_cnt", unord_cnt, 16'd1);

        // random traffic; operands only change when a lane is idle or just won
        for (int n = 0; n < 60; n++) begin
            rsp_ready = ($urandom_range(3, 0) != 0);
            cycle(g, s, sv);
            for (int i = 0; i < 4; i++)
                if (!req_valid[i] || g == i) begin
                    req_valid[i]      = ($urandom_range(1, 0) == 1);
                    req_a[16*i +: 16] = rand_op();
                    req_b[16*i +: 16] = rand_op();
                end
        end

        // 6. saturation on the 2-bit counter, from a mid-traffic reset
        rst = 1'b1;
        cycle(g, s, sv);
        rst         = 1'b0;
        rsp_ready   = 1'b1;
        req_a[15:0] = 16'h3C00;
        req_b[15:0] = 16'hFC01;
        req_valid   = 4'h1;
        for (int k = 0; k < 5; k++) begin
            cycle(g, s, sv);
            chk("sat_cnt", unord_cnt2, sat_seq[k]);
        end
        chk("wide_cnt", unord_cnt, 16'd5);
        req_valid = 4'h0;
        cycle(g, s, sv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp16_cmp_arb.md
Name: fp16_cmp_arb

Overview:
Round-robin arbiter that shares one fp16_cmp comparator instance among NUM_REQ requesters. Each requester presents an operand pair (a, b) with a valid/ready handshake. The block grants one requester per cycle, registers the comparison result with the winning requester's ID in a one-entry output slot, and drives a valid/ready response port. It also keeps a saturating count of unordered (NaN) results for debug.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.
CNT_W, 16, width of the unordered-result counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_a  in  16*NUM_REQ  operand a; requester i uses bits [16*i+15:16*i].
req_b  in  16*NUM_REQ  operand b; same packing as req_a.
req_ready  out  NUM_REQ  one-hot grant; at most one bit high per cycle.
rsp_valid  out  1  output slot holds a result.
rsp_ready  in  1  consumer accepts the result.
rsp_id  out  ID_W  index of the requester that owns the result.
rsp_lt  out  1  a < b.
rsp_eq  out  1  a == b.
rsp_gt  out  1  a > b.
rsp_unord  out  1  a or b is NaN.
unord_cnt  out  CNT_W  saturating count of accepted unordered results.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rsp_valid=0; rsp_id, rsp_lt, rsp_eq, rsp_gt and rsp_unord = 0.
  - unord_cnt=0; round-robin pointer rr_ptr=0.
  - req_ready is forced to 0 while rst=1.
  - Reset mid-operation discards the slot contents with no response; the requester must re-present its request.
- Slot availability: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - When slot_free and at least one req_valid is set, grant the first set req_valid[i], scanning i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[i] = grant[i]. req_ready never depends on rsp_valid of the same cycle except through slot_free.
  - A requester may see req_ready high only while its req_valid is high.
- Handshake: a transfer on requester i occurs when req_valid[i] && req_ready[i].
  - Requesters must hold req_valid and operands stable until the transfer completes.
  - The arbiter may grant others in the meantime; no fairness is violated by this.
- Datapath:
  - The granted requester's operands are muxed into a single combinational fp16_cmp.
  - On transfer, at the same edge: the slot captures lt/eq/gt/unord and rsp_id=i, and rsp_valid=1.
  - Latency is 1 cycle from the accepting edge to rsp_valid.
- Pointer update: on transfer, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Output slot:
  - rsp_* fields hold stable while rsp_valid && !rsp_ready.
  - A drain with no new transfer clears rsp_valid.
  - Drain plus a new transfer in the same cycle loads the new result with no bubble, giving 1 result per cycle throughput.
- unord_cnt:
  - Increments on each transfer whose compare result has unord=1.
  - Saturates at 2**CNT_W-1; no wrap.
  - Clear only by reset.
- Compare semantics:
  - NaN (exp=1F, mant!=0) on either operand gives unord=1 with lt=eq=gt=0.
  - +0 and -0 compare equal.
  - Infinities are ordered normally.
  - Exactly one of lt/eq/gt/unord is set.
- States: per-slot EMPTY/FULL, encoded as rsp_valid. Transitions are EMPTY->FULL on transfer, FULL->EMPTY on drain without transfer, and FULL->FULL on transfer (including drain+transfer).
- Lanes with req_valid low and an index >= NUM_REQ are never granted.

Test Plan:
1. Reset: hold rst for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, unord_cnt=0. First grant after release goes to requester 0.
2. Single request: req0 a=0x3C00 (1.0), b=0x4000 (2.0), rsp_ready=1 -> req_ready=0001 in cycle 0. Cycle 1 gives rsp_valid=1, rsp_id=0, lt=1.
3. Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one response per cycle, no bubbles.
4. Backpressure: slot full and rsp_ready=0 for 3 cycles -> req_ready=0000 and rsp fields stable. Raising rsp_ready drains the slot and grants the next requester in the same cycle.
5. Specials:
   - a=0x0000, b=0x8000 -> eq=1.
   - a=0x7C00, b=0x7BFF -> gt=1.
   - a=0x7E00 (NaN), b=0x3C00 -> unord=1 and unord_cnt increments by 1.
   - a=0xC000, b=0xBC00 -> lt=1.
6. Saturation: CNT_W=2, present 5 NaN compares -> unord_cnt = 1, 2, 3, 3, 3.
